// File: rtl/gshare_index_unit.sv
// gshare_index_unit: builds the gshare index (PC bits XOR speculative GHR)
// for a 256-entry pattern history table. It shares the table's single
// address port between lookups and resolution updates, and keeps an
// in-order queue of in-flight branches so the GHR can be repaired.
module gshare_index_unit #(
  parameter int PC_W   = 32,
  parameter int PC_LSB = 2,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  input  logic [PC_W-1:0]            req_pc,
  output logic                       req_ready,
  output logic                       pred_valid,
  output logic                       pred_taken,
  input  logic                       res_valid,
  input  logic                       res_taken,
  output logic                       mispredict,
  output logic [7:0]                 pht_addr,
  output logic                       pht_request,
  output logic                       pht_result,
  output logic                       pht_taken,
  input  logic                       pht_prediction,
  output logic [$clog2(DEPTH):0]     inflight
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [7:0] idx;
    logic [7:0] ghr;
    logic       pred;
  } ent_t;

  ent_t          q_mem [DEPTH];
  logic [7:0]    ghr_q, ghr_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pv_q, pt_q, mis_q;

  logic [7:0] lookup_idx;
  logic       not_empty, not_full, upd, lk, mis_now;
  ent_t       head;

  assign lookup_idx = req_pc[PC_LSB+7:PC_LSB] ^ ghr_q;
  assign not_empty  = (cnt_q != '0);
  assign not_full   = (cnt_q != CW'(DEPTH));
  assign head       = q_mem[head_q];
  // Resolution owns the port whenever there is something to resolve.
  assign upd        = !reset && res_valid && not_empty;
  assign lk         = !reset && req_valid && not_full && !upd;
  assign mis_now    = upd && (res_taken != head.pred);

  assign req_ready   = !reset && not_full && !upd;
  assign pht_request = lk;
  assign pht_result  = upd;
  assign pht_taken   = res_taken;
  assign pred_valid  = pv_q;
  assign pred_taken  = pt_q;
  assign mispredict  = mis_q;
  assign inflight    = cnt_q;

  // Table address: head's stored index on updates, the fresh hash otherwise.
  always_comb begin
    pht_addr = lookup_idx;
    if (reset)    pht_addr = '0;
    else if (upd) pht_addr = head.idx;
  end

  // Next-state for GHR and queue pointers; at most one push or pop per cycle.
  always_comb begin
    ghr_d  = ghr_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (lk) begin
      ghr_d  = {ghr_q[6:0], pht_prediction};
      tail_d = tail_q + PW'(1);
      cnt_d  = cnt_q + CW'(1);
    end else if (upd) begin
      if (mis_now) begin
        // Rewind history to the mispredicted branch and drop everything younger.
        ghr_d  = {head.ghr[6:0], res_taken};
        head_d = '0;
        tail_d = '0;
        cnt_d  = '0;
      end else begin
        head_d = head_q + PW'(1);
        cnt_d  = cnt_q - CW'(1);
      end
    end
  end

  // Queue payload storage; contents are don't-care while the entry is empty.
  always_ff @(posedge clk) begin
    if (lk) q_mem[tail_q] <= '{idx: lookup_idx, ghr: ghr_q, pred: pht_prediction};
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      pv_q   <= 1'b0;
      pt_q   <= 1'b0;
      mis_q  <= 1'b0;
    end else begin
      ghr_q  <= ghr_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      pv_q   <= lk;
      if (lk) pt_q <= pht_prediction;
      mis_q  <= mis_now;
    end
  end
endmodule

// File: tb/tb_gshare_index_unit.sv
// Bench for gshare_index_unit: directed scenarios plus a random run, each
// cycle checked against a queue-based model of the branch predictor front-end.
module tb_gshare_index_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_pc = '0;
  logic        req_ready;
  logic        pred_valid, pred_taken;
  logic        res_valid = 1'b0, res_taken = 1'b0;
  logic        mispredict;
  logic [7:0]  pht_addr;
  logic        pht_request, pht_result, pht_taken;
  logic        pht_prediction = 1'b0;
  logic [2:0]  inflight;

  int tests = 0;
  int fails = 0;

  gshare_index_unit #(.PC_W(32), .PC_LSB(2), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_taken(res_taken), .mispredict(mispredict),
    .pht_addr(pht_addr), .pht_request(pht_request), .pht_result(pht_result),
    .pht_taken(pht_taken), .pht_prediction(pht_prediction), .inflight(inflight)
  );

  always #5 clk = ~clk;

  // Reference model: history as a plain byte, in-flight branches as a queue.
  typedef struct {
    bit [7:0] idx;
    bit [7:0] ghr;
    bit       pred;
  } ent_t;
  ent_t     mq[$];
  bit [7:0] mghr;
  bit       m_pv, m_pt, m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 1'b1; res_valid = 1'b1; req_pc = $urandom; pht_prediction = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = 1'b0; res_valid = 1'b0; req_pc = '0;
    mq.delete(); mghr = 8'h00; m_pv = 0; m_pt = 0; m_mis = 0;
    chk("rst_inflight", inflight, 0);
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_pred_taken", pred_taken, 0);
    chk("rst_mispredict", mispredict, 0);
    #1;
    chk("rst_pht_request", pht_request, 0);
    chk("rst_pht_result", pht_result, 0);
    chk("rst_pht_addr", pht_addr, 8'h00);
  endtask

  // One clock cycle: drive inputs, check the combinational port, clock,
  // advance the model and check the registered outputs.
  task automatic step(input bit rv, input bit [31:0] pc, input bit sv, input bit st, input bit pp);
    bit       upd, lk;
    bit [7:0] hidx, eaddr;
    int       n;
    req_valid = rv; req_pc = pc; res_valid = sv; res_taken = st; pht_prediction = pp;
    #1;
    n     = mq.size();
    upd   = sv && (n != 0);
    lk    = !upd && rv && (n < DEPTH);
    hidx  = 8'((pc >> 2) & 32'hFF) ^ mghr;
    eaddr = upd ? mq[0].idx : hidx;
    chk("req_ready", req_ready, (!upd && n < DEPTH));
    chk("pht_request", pht_request, lk);
    chk("pht_result", pht_result, upd);
    chk("pht_addr", pht_addr, eaddr);
    if (upd) chk("pht_taken", pht_taken, st);
    @(posedge clk); #1;
    m_pv = lk; m_mis = 0;
    if (lk) begin
      mq.push_back('{idx: hidx, ghr: mghr, pred: pp});
      mghr = {mghr[6:0], pp};
      m_pt = pp;
    end else if (upd) begin
      if (st == mq[0].pred) void'(mq.pop_front());
      else begin
        mghr  = {mq[0].ghr[6:0], st};
        mq.delete();
        m_mis = 1;
      end
    end
    chk("pred_valid", pred_valid, m_pv);
    if (m_pv) chk("pred_taken", pred_taken, m_pt);
    chk("mispredict", mispredict, m_mis);
    chk("inflight", inflight, mq.size());
  endtask

  initial begin
    do_reset();

    // First lookup: pc 0x40 -> index 0x10, predicted taken.
    step(1, 32'h40, 0, 0, 1);
    chk("ghr_after_first", mghr, 8'h01);
    // Correct resolution of it, then GHR=0x01 lookup (0x11) and correct resolve.
    step(0, 32'h0, 1, 1, 0);
    step(1, 32'h40, 0, 0, 0);
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 0, 0, 0);

    // Three taken predictions from GHR=0, then a not-taken resolve.
    do_reset();
    repeat (3) step(1, $urandom, 0, 0, 1);
    step(0, 32'h0, 1, 0, 0);
    chk("ghr_after_mispredict", mghr, 8'h00);
    step(0, 32'h40, 0, 0, 0);

    // Fill the queue, hold the request, then collide request with resolution.
    do_reset();
    repeat (DEPTH) step(1, $urandom, 0, 0, $urandom_range(0, 1));
    repeat (2) step(1, 32'h80, 0, 0, 1);
    step(1, 32'h80, 1, mq[0].pred, 1);
    step(1, 32'h80, 0, 0, 1);

    // Resolution with an empty queue is ignored.
    do_reset();
    step(0, 32'h44, 1, 1, 0);
    step(0, 32'h44, 1, 0, 1);

    // Reset with entries in flight drops them without updates.
    repeat (3) step(1, $urandom, 0, 0, 1);
    do_reset();
    repeat (3) step(0, $urandom, 1, $urandom_range(0, 1), 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit sv;
      bit st;
      sv = ($urandom_range(0, 3) == 0);
      st = (mq.size() != 0 && $urandom_range(0, 3) != 0) ? mq[0].pred : 1'($urandom);
      step($urandom_range(0, 1), $urandom, sv, st, $urandom_range(0, 1));
      if (i % 97 == 96) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
